// File: rtl/pill_line_pkg.sv
// pill_line_pkg: shared widths, limits and state encodings for the bottling line.
package pill_line_pkg;
  localparam int PILL_W = 10;
  localparam int BOTTLE_W = 7;
  localparam int PILL_MAX = 999;
  localparam int BOTTLE_MAX = 99;
  typedef enum logic [1:0] {F_IDLE, F_HIGH, F_LOW} feed_state_t;
  typedef enum logic [1:0] {C_READY, C_MOVING, C_JAM} conv_state_t;
endpackage

// File: rtl/pill_pulse_gen.sv
// pill_pulse_gen: hopper pill pulse train; dispense strobes on the cycle before each rising edge.
module pill_pulse_gen
  import pill_line_pkg::*;
#(
  parameter int PERIOD  = 1000,
  parameter int PULSE_W = 500
) (
  input  logic clk_1khz,
  input  logic rst_n,
  input  logic start_ok,
  output logic pulse,
  output logic dispense
);
  localparam int CW = $clog2(PERIOD);
  feed_state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic pulse_n;
  // The phase counter keeps running through F_LOW so rising edges are exactly PERIOD apart.
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    pulse_n = pulse;
    dispense = 1'b0;
    case (state)
      F_IDLE: if (start_ok) begin
        state_n = F_HIGH;
        cnt_n = '0;
        pulse_n = 1'b1;
        dispense = 1'b1;
      end
      F_HIGH: begin
        cnt_n = cnt + 1'b1;
        if (cnt == CW'(PULSE_W - 1)) begin
          state_n = F_LOW;
          pulse_n = 1'b0;
        end
      end
      F_LOW: if (cnt == CW'(PERIOD - 1)) begin
        cnt_n = '0;
        state_n = start_ok ? F_HIGH : F_IDLE;
        pulse_n = start_ok;
        dispense = start_ok;
      end else cnt_n = cnt + 1'b1;
      default: state_n = F_IDLE;
    endcase
  end
  always_ff @(posedge clk_1khz or negedge rst_n)
    if (!rst_n) begin
      state <= F_IDLE;
      cnt <= '0;
      pulse <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      pulse <= pulse_n;
    end
endmodule

// File: rtl/pill_feeder_sim.sv
// pill_feeder_sim: plant model of hopper and conveyor with stock tracking and fault injection.
module pill_feeder_sim
  import pill_line_pkg::*;
#(
  parameter int PERIOD     = 1000,
  parameter int PULSE_W    = 500,
  parameter int STOCK_MAX  = 999,
  parameter int STOCK_INIT = 50,
  parameter int REFILL_AMT = 100,
  parameter int MOVE_CYC   = 1500
) (
  input  logic                clk_1khz,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                hopper_stop,
  input  logic                hopper_add,
  input  logic                conveyor_stop,
  input  logic                bottle_req,
  output logic                hopper_signal,
  output logic                conveyor_signal,
  output logic                bottle_ready,
  output logic [PILL_W-1:0]   stock,
  output logic                hopper_empty,
  output logic [BOTTLE_W-1:0] bottle_count
);
  localparam int SW = PILL_W + 1;
  localparam int TW = $clog2(MOVE_CYC + 1);
  logic add_q, refill, dispense, start_ok, done;
  logic [SW-1:0] stock_sum;
  logic [PILL_W-1:0] stock_n;
  conv_state_t cstate, cstate_n;
  logic [TW-1:0] timer, timer_n;
  assign start_ok = enable && !hopper_stop && stock != '0;
  assign refill = hopper_add && !add_q;
  // Extra headroom bit lets refill overshoot before saturating; dispense only fires with stock > 0.
  assign stock_sum = {1'b0, stock} + (refill ? SW'(REFILL_AMT) : '0) - SW'(dispense);
  assign stock_n = stock_sum > SW'(STOCK_MAX) ? PILL_W'(STOCK_MAX) : stock_sum[PILL_W-1:0];
  pill_pulse_gen #(.PERIOD(PERIOD), .PULSE_W(PULSE_W)) u_gen (
    .clk_1khz(clk_1khz),
    .rst_n(rst_n),
    .start_ok(start_ok),
    .pulse(hopper_signal),
    .dispense(dispense)
  );
  // A jam freezes the timer; the resume edge counts as a moving cycle.
  always_comb begin
    cstate_n = cstate;
    timer_n = timer;
    done = 1'b0;
    case (cstate)
      C_READY: if (bottle_req) begin
        cstate_n = C_MOVING;
        timer_n = TW'(MOVE_CYC - 1);
      end
      C_MOVING: if (timer == '0) begin
        cstate_n = C_READY;
        done = 1'b1;
      end else if (conveyor_stop) cstate_n = C_JAM;
      else timer_n = timer - 1'b1;
      C_JAM: if (!conveyor_stop) begin
        cstate_n = C_MOVING;
        timer_n = timer - 1'b1;
      end
      default: cstate_n = C_READY;
    endcase
  end
  always_ff @(posedge clk_1khz or negedge rst_n)
    if (!rst_n) begin
      add_q <= hopper_add;
      stock <= PILL_W'(STOCK_INIT);
      hopper_empty <= (STOCK_INIT == 0);
      conveyor_signal <= 1'b1;
      bottle_ready <= 1'b1;
      bottle_count <= '0;
      cstate <= C_READY;
      timer <= '0;
    end else begin
      add_q <= hopper_add;
      stock <= stock_n;
      hopper_empty <= (stock_n == '0);
      conveyor_signal <= !conveyor_stop;
      bottle_ready <= (cstate_n == C_READY);
      bottle_count <= done ? (bottle_count == BOTTLE_W'(BOTTLE_MAX) ? '0 : bottle_count + 1'b1) : bottle_count;
      cstate <= cstate_n;
      timer <= timer_n;
    end
endmodule

// File: tb/tb_pill_feeder_sim.sv
// tb_pill_feeder_sim: directed scenario tests with shortened timing parameters.
module tb_pill_feeder_sim;
  localparam int PERIOD = 20;
  localparam int PULSE_W = 8;
  localparam int MOVE_CYC = 30;
  logic clk = 1'b0;
  logic rst_n, enable, hopper_stop, hopper_add, conveyor_stop, bottle_req;
  logic hopper_signal, conveyor_signal, bottle_ready, hopper_empty;
  logic [9:0] stock;
  logic [6:0] bottle_count;
  int errors = 0;
  int checks = 0;
  pill_feeder_sim #(
    .PERIOD(PERIOD), .PULSE_W(PULSE_W), .STOCK_MAX(999),
    .STOCK_INIT(50), .REFILL_AMT(100), .MOVE_CYC(MOVE_CYC)
  ) dut (
    .clk_1khz(clk), .rst_n(rst_n), .enable(enable), .hopper_stop(hopper_stop),
    .hopper_add(hopper_add), .conveyor_stop(conveyor_stop), .bottle_req(bottle_req),
    .hopper_signal(hopper_signal), .conveyor_signal(conveyor_signal),
    .bottle_ready(bottle_ready), .stock(stock), .hopper_empty(hopper_empty),
    .bottle_count(bottle_count)
  );
  always #5 clk = ~clk;
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic test_reset;
    rst_n = 1'b0; enable = 1'b0; hopper_stop = 1'b0; hopper_add = 1'b1;
    conveyor_stop = 1'b0; bottle_req = 1'b0;
    tick(3);
    checks++; if (hopper_signal !== 1'b0) begin errors++; $display("FAIL rst_hs: got %0b want 0", hopper_signal); end
    checks++; if (conveyor_signal !== 1'b1) begin errors++; $display("FAIL rst_conv: got %0b want 1", conveyor_signal); end
    checks++; if (bottle_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %0b want 1", bottle_ready); end
    checks++; if (stock !== 10'd50) begin errors++; $display("FAIL rst_stock: got %0d want 50", stock); end
    checks++; if (hopper_empty !== 1'b0) begin errors++; $display("FAIL rst_empty: got %0b want 0", hopper_empty); end
    checks++; if (bottle_count !== 7'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", bottle_count); end
    rst_n = 1'b1;
    tick(3);
    checks++; if (stock !== 10'd50) begin errors++; $display("FAIL add_held_at_reset: got %0d want 50", stock); end
    hopper_add = 1'b0;
    tick(1);
  endtask
  task automatic test_pulse_train;
    int mism;
    logic exp_hs;
    mism = 0;
    enable = 1'b1;
    for (int k = 1; k <= 3 * PERIOD; k++) begin
      @(negedge clk);
      exp_hs = ((k - 1) % PERIOD) < PULSE_W;
      if (hopper_signal !== exp_hs) mism++;
    end
    checks++; if (mism != 0) begin errors++; $display("FAIL pulse_shape: got %0d bad samples want 0", mism); end
    checks++; if (stock !== 10'd47) begin errors++; $display("FAIL stock_after_3: got %0d want 47", stock); end
    enable = 1'b0;
    tick(2 * PERIOD);
    checks++; if (hopper_signal !== 1'b0) begin errors++; $display("FAIL idle_hs: got %0b want 0", hopper_signal); end
    checks++; if (stock !== 10'd47) begin errors++; $display("FAIL idle_stock: got %0d want 47", stock); end
  endtask
  task automatic test_empty_refill;
    int n, rises;
    logic prev;
    n = 0;
    enable = 1'b1;
    while (stock !== 10'd2 && n < 2000) begin @(negedge clk); n++; end
    checks++; if (stock !== 10'd2) begin errors++; $display("FAIL reach_stock2: got %0d want 2", stock); end
    prev = hopper_signal;
    rises = 0;
    for (int k = 0; k < 5 * PERIOD; k++) begin
      @(negedge clk);
      if (hopper_signal && !prev) rises++;
      prev = hopper_signal;
    end
    checks++; if (rises != 2) begin errors++; $display("FAIL drain_rises: got %0d want 2", rises); end
    checks++; if (hopper_signal !== 1'b0) begin errors++; $display("FAIL drained_hs: got %0b want 0", hopper_signal); end
    checks++; if (stock !== 10'd0) begin errors++; $display("FAIL drained_stock: got %0d want 0", stock); end
    checks++; if (hopper_empty !== 1'b1) begin errors++; $display("FAIL empty_flag: got %0b want 1", hopper_empty); end
    hopper_add = 1'b1;
    tick(1);
    checks++; if (stock !== 10'd100) begin errors++; $display("FAIL refill_stock: got %0d want 100", stock); end
    checks++; if (hopper_empty !== 1'b0) begin errors++; $display("FAIL refill_empty: got %0b want 0", hopper_empty); end
    checks++; if (hopper_signal !== 1'b0) begin errors++; $display("FAIL refill_hs_pre: got %0b want 0", hopper_signal); end
    tick(1);
    checks++; if (hopper_signal !== 1'b1) begin errors++; $display("FAIL resume_hs: got %0b want 1", hopper_signal); end
    checks++; if (stock !== 10'd99) begin errors++; $display("FAIL resume_stock: got %0d want 99", stock); end
    hopper_add = 1'b0;
    enable = 1'b0;
    tick(2 * PERIOD);
  endtask
  task automatic test_hopper_stop;
    int highs, rises;
    logic prev;
    enable = 1'b1;
    tick(3);
    hopper_stop = 1'b1;
    highs = 0; rises = 0; prev = hopper_signal;
    for (int k = 4; k <= 45; k++) begin
      @(negedge clk);
      if (hopper_signal) highs++;
      if (hopper_signal && !prev) rises++;
      prev = hopper_signal;
    end
    checks++; if (highs != PULSE_W - 3) begin errors++; $display("FAIL stop_tail_width: got %0d want %0d", highs, PULSE_W - 3); end
    checks++; if (rises != 0) begin errors++; $display("FAIL stop_blocks: got %0d rises want 0", rises); end
    hopper_stop = 1'b0;
    tick(1);
    checks++; if (hopper_signal !== 1'b1) begin errors++; $display("FAIL stop_release_hs: got %0b want 1", hopper_signal); end
    checks++; if (stock !== 10'd97) begin errors++; $display("FAIL stop_stock: got %0d want 97", stock); end
    enable = 1'b0;
    tick(2 * PERIOD);
  endtask
  task automatic test_refill_saturate;
    repeat (8) begin hopper_add = 1'b1; tick(1); hopper_add = 1'b0; tick(1); end
    checks++; if (stock !== 10'd897) begin errors++; $display("FAIL refill_x8: got %0d want 897", stock); end
    enable = 1'b1; hopper_add = 1'b1;
    tick(1);
    checks++; if (stock !== 10'd996) begin errors++; $display("FAIL net_update: got %0d want 996", stock); end
    checks++; if (hopper_signal !== 1'b1) begin errors++; $display("FAIL net_hs: got %0b want 1", hopper_signal); end
    hopper_add = 1'b0;
    tick(PERIOD - 1);
    hopper_add = 1'b1;
    tick(1);
    checks++; if (stock !== 10'd999) begin errors++; $display("FAIL sat_with_dispense: got %0d want 999", stock); end
    checks++; if (hopper_signal !== 1'b1) begin errors++; $display("FAIL sat_hs: got %0b want 1", hopper_signal); end
    enable = 1'b0; hopper_add = 1'b0;
    tick(1);
    hopper_add = 1'b1;
    tick(1);
    checks++; if (stock !== 10'd999) begin errors++; $display("FAIL sat_hold: got %0d want 999", stock); end
    hopper_add = 1'b0;
    tick(2 * PERIOD);
  endtask
  task automatic move(output int low);
    bottle_req = 1'b1;
    tick(1);
    bottle_req = 1'b0;
    low = 0;
    while (!bottle_ready && low < 200) begin low++; @(negedge clk); end
  endtask
  task automatic test_conveyor;
    int low, bad;
    move(low);
    checks++; if (low != MOVE_CYC) begin errors++; $display("FAIL move_time: got %0d want %0d", low, MOVE_CYC); end
    checks++; if (bottle_count !== 7'd1) begin errors++; $display("FAIL count_1: got %0d want 1", bottle_count); end
    bad = 0;
    repeat (98) begin move(low); if (low != MOVE_CYC) bad++; end
    checks++; if (bad != 0) begin errors++; $display("FAIL move_times: got %0d bad want 0", bad); end
    checks++; if (bottle_count !== 7'd99) begin errors++; $display("FAIL count_99: got %0d want 99", bottle_count); end
    move(low);
    checks++; if (bottle_count !== 7'd0) begin errors++; $display("FAIL count_wrap: got %0d want 0", bottle_count); end
    checks++; if (bottle_ready !== 1'b1) begin errors++; $display("FAIL ready_after_wrap: got %0b want 1", bottle_ready); end
  endtask
  task automatic test_jam;
    int k;
    bottle_req = 1'b1;
    tick(1);
    bottle_req = 1'b0;
    tick(13);
    checks++; if (conveyor_signal !== 1'b1) begin errors++; $display("FAIL conv_pre_jam: got %0b want 1", conveyor_signal); end
    conveyor_stop = 1'b1;
    tick(1);
    checks++; if (conveyor_signal !== 1'b0) begin errors++; $display("FAIL conv_lag: got %0b want 0", conveyor_signal); end
    tick(1);
    bottle_req = 1'b1;
    tick(1);
    bottle_req = 1'b0;
    tick(3);
    checks++; if (conveyor_signal !== 1'b0) begin errors++; $display("FAIL conv_in_jam: got %0b want 0", conveyor_signal); end
    conveyor_stop = 1'b0;
    tick(1);
    checks++; if (conveyor_signal !== 1'b1) begin errors++; $display("FAIL conv_release: got %0b want 1", conveyor_signal); end
    k = 21;
    while (!bottle_ready && k < 300) begin @(negedge clk); k++; end
    checks++; if (k != MOVE_CYC + 7) begin errors++; $display("FAIL jam_ready_at: got %0d want %0d", k, MOVE_CYC + 7); end
    checks++; if (bottle_count !== 7'd1) begin errors++; $display("FAIL jam_count: got %0d want 1", bottle_count); end
    tick(5);
    checks++; if (bottle_ready !== 1'b1 || bottle_count !== 7'd1) begin errors++; $display("FAIL jam_req_ignored: got ready=%0b count=%0d want 1 1", bottle_ready, bottle_count); end
  endtask
  task automatic test_reset_mid_move;
    enable = 1'b1; bottle_req = 1'b1;
    tick(1);
    bottle_req = 1'b0;
    tick(3);
    checks++; if (hopper_signal !== 1'b1 || bottle_ready !== 1'b0) begin errors++; $display("FAIL pre_reset: got hs=%0b ready=%0b want 1 0", hopper_signal, bottle_ready); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (hopper_signal !== 1'b0) begin errors++; $display("FAIL async_hs: got %0b want 0", hopper_signal); end
    checks++; if (bottle_ready !== 1'b1) begin errors++; $display("FAIL async_ready: got %0b want 1", bottle_ready); end
    checks++; if (stock !== 10'd50) begin errors++; $display("FAIL async_stock: got %0d want 50", stock); end
    checks++; if (bottle_count !== 7'd0) begin errors++; $display("FAIL async_count: got %0d want 0", bottle_count); end
    checks++; if (conveyor_signal !== 1'b1 || hopper_empty !== 1'b0) begin errors++; $display("FAIL async_misc: got conv=%0b empty=%0b want 1 0", conveyor_signal, hopper_empty); end
    enable = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(2);
    checks++; if (stock !== 10'd50 || bottle_ready !== 1'b1) begin errors++; $display("FAIL post_reset: got stock=%0d ready=%0b want 50 1", stock, bottle_ready); end
  endtask
  initial begin
    test_reset;
    test_pulse_train;
    test_empty_refill;
    test_hopper_stop;
    test_refill_saturate;
    test_conveyor;
    test_jam;
    test_reset_mid_move;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
